// File: rtl/pc_ctrl_pkg.sv
// Shared constants, state encoding and instruction classification for pc_ctrl.
package pc_ctrl_pkg;

  localparam int DATA_W = 16;
  localparam int IMM_W  = 8;
  localparam int FLAG_W = 5;

  // Major opcodes (IR[15:12])
  localparam logic [3:0] OP_RTYPE   = 4'b0000;
  localparam logic [3:0] OP_SPECIAL = 4'b0100;
  localparam logic [3:0] OP_CMPI    = 4'b1011;
  localparam logic [3:0] OP_BCOND   = 4'b1100;

  // Extended opcodes (IR[7:4])
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_CMP   = 4'b1011;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  // Condition codes (IR[11:8] of Bcond/Jcond)
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_HI = 4'b0100;
  localparam logic [3:0] COND_LS = 4'b0101;
  localparam logic [3:0] COND_GT = 4'b0110;
  localparam logic [3:0] COND_LE = 4'b0111;
  localparam logic [3:0] COND_FS = 4'b1000;
  localparam logic [3:0] COND_FC = 4'b1001;
  localparam logic [3:0] COND_LO = 4'b1010;
  localparam logic [3:0] COND_HS = 4'b1011;
  localparam logic [3:0] COND_LT = 4'b1100;
  localparam logic [3:0] COND_GE = 4'b1101;
  localparam logic [3:0] COND_UC = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Bit positions inside flags = {C,L,F,Z,N}
  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    S_RST = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    MEM   = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    I_ALU   = 3'd0,
    I_CMP   = 3'd1,
    I_BCOND = 3'd2,
    I_JCOND = 3'd3,
    I_JAL   = 3'd4,
    I_LOAD  = 3'd5,
    I_STOR  = 3'd6
  } iclass_t;

  // Collapse an instruction word into the sequencing class the controller cares about.
  // Anything not recognised (including reserved SPECIAL extensions) behaves as ALU.
  function automatic iclass_t decode_class(input logic [DATA_W-1:0] ir);
    iclass_t cls;
    cls = I_ALU;
    case (ir[15:12])
      OP_BCOND: cls = I_BCOND;
      OP_CMPI:  cls = I_CMP;
      OP_RTYPE: if (ir[7:4] == EXT_CMP) cls = I_CMP;
      OP_SPECIAL: begin
        case (ir[7:4])
          EXT_LOAD:  cls = I_LOAD;
          EXT_STOR:  cls = I_STOR;
          EXT_JAL:   cls = I_JAL;
          EXT_JCOND: cls = I_JCOND;
          default:   cls = I_ALU;
        endcase
      end
      default: cls = I_ALU;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/pc_ctrl_cond_eval.sv
// Branch/jump condition evaluator: maps a 4-bit condition code and the status flags to take.
module cond_eval
  import pc_ctrl_pkg::*;
(
  input  logic [3:0]        cond,
  input  logic [FLAG_W-1:0] flags,
  output logic              take
);

  // Pure lookup of the condition table against the current flags.
  always_comb begin
    take = 1'b0;
    case (cond)
      COND_EQ: take = flags[FLAG_Z];
      COND_NE: take = ~flags[FLAG_Z];
      COND_CS: take = flags[FLAG_C];
      COND_CC: take = ~flags[FLAG_C];
      COND_HI: take = flags[FLAG_L];
      COND_LS: take = ~flags[FLAG_L];
      COND_GT: take = flags[FLAG_N];
      COND_LE: take = ~flags[FLAG_N];
      COND_FS: take = flags[FLAG_F];
      COND_FC: take = ~flags[FLAG_F];
      COND_LO: take = ~flags[FLAG_L] & ~flags[FLAG_Z];
      COND_HS: take = flags[FLAG_L] | flags[FLAG_Z];
      COND_LT: take = ~flags[FLAG_N] & ~flags[FLAG_Z];
      COND_GE: take = flags[FLAG_N] | flags[FLAG_Z];
      COND_UC: take = 1'b1;
      COND_NV: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_ctrl.sv
// Fetch/sequencing controller: latches IR, decodes control flow and memory ops,
// and issues exactly one PC update per instruction to the pc block.
module pc_ctrl
  import pc_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] instr,
  input  logic [FLAG_W-1:0] flags,
  input  logic              stall,
  output logic              irEn,
  output logic              pcEn,
  output logic              branch,
  output logic              jump,
  output logic [IMM_W-1:0]  disp,
  output logic [3:0]        rdst,
  output logic [3:0]        rsrc,
  output logic              regWrite,
  output logic              raWrite,
  output logic              memWrite,
  output logic              addrSel
);

  state_t            state_reg;
  state_t            state_next;
  logic [DATA_W-1:0] ir_reg;
  iclass_t           iclass;
  logic              cond_take;
  logic              advance;

  assign iclass = decode_class(ir_reg);

  // S_RST always moves on, so a stall asserted during reset recovery is ignored.
  assign advance = ~stall | (state_reg == S_RST);

  assign disp = ir_reg[7:0];
  assign rdst = ir_reg[11:8];
  assign rsrc = ir_reg[3:0];

  cond_eval u_cond_eval (
    .cond  (ir_reg[11:8]),
    .flags (flags),
    .take  (cond_take)
  );

  // State and instruction register; reset clears both so every output drops immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_RST;
      ir_reg    <= '0;
    end else begin
      if (advance) state_reg <= state_next;
      if (state_reg == FETCH && !stall) ir_reg <= instr;
    end
  end

  // Next-state and strobe decode; stall masks the strobes that commit architectural state.
  always_comb begin
    state_next = state_reg;
    irEn       = 1'b0;
    pcEn       = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    regWrite   = 1'b0;
    raWrite    = 1'b0;
    memWrite   = 1'b0;
    addrSel    = 1'b0;
    case (state_reg)
      S_RST: state_next = FETCH;
      FETCH: begin
        irEn       = 1'b1;
        state_next = EXEC;
      end
      EXEC: begin
        state_next = FETCH;
        case (iclass)
          I_BCOND: begin
            pcEn   = 1'b1;
            branch = cond_take;
          end
          I_JCOND: begin
            pcEn = 1'b1;
            jump = cond_take;
          end
          I_JAL: begin
            pcEn     = 1'b1;
            jump     = 1'b1;
            regWrite = 1'b1;
            raWrite  = 1'b1;
          end
          I_LOAD, I_STOR: begin
            addrSel    = 1'b1;
            state_next = MEM;
          end
          I_CMP: pcEn = 1'b1;
          default: begin
            pcEn     = 1'b1;
            regWrite = 1'b1;
          end
        endcase
      end
      MEM: begin
        addrSel    = 1'b1;
        pcEn       = 1'b1;
        regWrite   = (iclass == I_LOAD);
        memWrite   = (iclass == I_STOR);
        state_next = FETCH;
      end
    endcase
    if (stall) begin
      irEn     = 1'b0;
      pcEn     = 1'b0;
      regWrite = 1'b0;
      memWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: the driver pushes per-cycle expected outputs, a negedge monitor compares.
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr = 16'h0000;
  logic [4:0]  flags = 5'b0;
  logic        stall = 1'b0;
  logic        irEn, pcEn, branch, jump, regWrite, raWrite, memWrite, addrSel;
  logic [7:0]  disp;
  logic [3:0]  rdst, rsrc;

  pc_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .flags(flags), .stall(stall),
    .irEn(irEn), .pcEn(pcEn), .branch(branch), .jump(jump), .disp(disp),
    .rdst(rdst), .rsrc(rsrc), .regWrite(regWrite), .raWrite(raWrite),
    .memWrite(memWrite), .addrSel(addrSel)
  );

  always #5 clk = ~clk;

  typedef enum {K_ALU, K_CMP, K_BR, K_JC, K_JAL, K_LD, K_ST} kind_t;
  typedef enum {P_RST, P_FETCH, P_EXEC, P_MEM} phase_t;

  logic [23:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] ir_m = 16'h0000;

  // pc / link-register model driven by the controller's strobes
  logic [15:0] pc_m = 16'h0000;
  logic [15:0] regs_m [16];

  wire [23:0] dut_vec = {irEn, pcEn, branch, jump, disp, rdst, rsrc,
                         regWrite, raWrite, memWrite, addrSel};

  function automatic logic cond_true(input logic [3:0] c, input logic [4:0] f);
    logic cf, lf, ff, zf, nf;
    logic r;
    {cf, lf, ff, zf, nf} = f;
    r = 1'b0;
    case (c)
      4'd0:  r = zf;        4'd1:  r = !zf;
      4'd2:  r = cf;        4'd3:  r = !cf;
      4'd4:  r = lf;        4'd5:  r = !lf;
      4'd6:  r = nf;        4'd7:  r = !nf;
      4'd8:  r = ff;        4'd9:  r = !ff;
      4'd10: r = !lf && !zf; 4'd11: r = lf || zf;
      4'd12: r = !nf && !zf; 4'd13: r = nf || zf;
      4'd14: r = 1'b1;      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Expected outputs for one cycle of an instruction in the given phase.
  function automatic logic [23:0] expect_vec(input phase_t p, input kind_t k, input logic [15:0] ir,
                                             input logic [4:0] f, input logic st);
    logic ie, pe, br, jp, rw, ra, mw, as;
    {ie, pe, br, jp, rw, ra, mw, as} = 8'b0;
    if (p == P_FETCH) ie = 1'b1;
    if (p == P_EXEC) begin
      case (k)
        K_ALU: begin pe = 1'b1; rw = 1'b1; end
        K_CMP: pe = 1'b1;
        K_BR:  begin pe = 1'b1; br = cond_true(ir[11:8], f); end
        K_JC:  begin pe = 1'b1; jp = cond_true(ir[11:8], f); end
        K_JAL: begin pe = 1'b1; jp = 1'b1; rw = 1'b1; ra = 1'b1; end
        default: as = 1'b1; // LOAD / STOR address phase
      endcase
    end
    if (p == P_MEM) begin
      as = 1'b1;
      pe = 1'b1;
      rw = (k == K_LD);
      mw = (k == K_ST);
    end
    if (st) begin ie = 1'b0; pe = 1'b0; rw = 1'b0; mw = 1'b0; end
    return {ie, pe, br, jp, ir[7:0], ir[11:8], ir[3:0], rw, ra, mw, as};
  endfunction

  // Monitor: pop and compare whenever an expectation is pending for this cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [23:0] e;
      e = exp_q.pop_front();
      n_vec++;
      if (dut_vec !== e) begin
        n_err++;
        $display("FAIL outputs t=%0t got=%h expected=%h", $time, dut_vec, e);
      end
    end
  end

  // pc block model: pc_ra = pc+1; jump loads dSrc, branch adds sign-extended disp.
  always @(posedge clk) begin
    if (rst && pcEn) begin
      if (regWrite && raWrite) regs_m[rdst] = pc_m + 16'd1;
      if (jump)        pc_m = regs_m[rsrc];
      else if (branch) pc_m = pc_m + {{8{disp[7]}}, disp};
      else             pc_m = pc_m + 16'd1;
    end
  end

  task automatic step(input logic [23:0] e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  task automatic run_phase(input phase_t p, input kind_t k, input logic [4:0] f, input int nst);
    for (int i = 0; i < nst; i++) begin
      stall = 1'b1;
      step(expect_vec(p, k, ir_m, f, 1'b1));
    end
    stall = 1'b0;
    step(expect_vec(p, k, ir_m, f, 1'b0));
  endtask

  task automatic run_instr(input logic [15:0] w, input kind_t k, input logic [4:0] f,
                           input int st_f, input int st_e, input int st_m);
    instr = w;
    flags = f;
    run_phase(P_FETCH, k, f, st_f);
    ir_m = w;
    run_phase(P_EXEC, k, f, st_e);
    if (k == K_LD || k == K_ST) run_phase(P_MEM, k, f, st_m);
  endtask

  function automatic int rnd_stall();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
  endfunction

  // Build a random instruction word of the chosen class.
  task automatic gen_instr(output logic [15:0] w, output kind_t k);
    logic [3:0] op, ext, a, b;
    logic [3:0] alu_ops [13];
    logic [3:0] rsv_ext [12];
    alu_ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hD, 4'hE, 4'hF};
    rsv_ext = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hD, 4'hE, 4'hF};
    a = 4'($urandom_range(0, 15));
    b = 4'($urandom_range(0, 15));
    k = kind_t'($urandom_range(0, 6));
    case (k)
      K_BR:  w = {4'hC, a, 8'($urandom_range(0, 255))};
      K_JC:  w = {4'h4, a, 4'hC, b};
      K_JAL: w = {4'h4, a, 4'h8, b};
      K_LD:  w = {4'h4, a, 4'h0, b};
      K_ST:  w = {4'h4, a, 4'h4, b};
      K_CMP: w = ($urandom_range(0, 1) == 0) ? {4'h0, a, 4'hB, b} : {4'hB, a, 8'($urandom_range(0, 255))};
      default: begin
        if ($urandom_range(0, 4) == 0) begin
          w = {4'h4, a, rsv_ext[$urandom_range(0, 11)], b};
        end else begin
          op  = alu_ops[$urandom_range(0, 12)];
          ext = 4'($urandom_range(0, 15));
          if (op == 4'h0 && ext == 4'hB) ext = 4'h5;
          w = {op, a, ext, b};
        end
      end
    endcase
  endtask

  initial begin
    logic [15:0] w;
    kind_t       k;
    for (int i = 0; i < 16; i++) regs_m[i] = 16'h0000;

    // Reset held: all outputs zero
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    step(24'h0);
    step(24'h0);
    rst = 1'b1;
    step(24'h0);  // S_RST cycle after release

    // ADDI cadence
    run_instr(16'h510A, K_ALU, 5'b0, 0, 0, 0);
    run_instr(16'h510A, K_ALU, 5'b0, 0, 0, 0);

    // Bcond EQ with Z set and clear
    run_instr(16'hC07F, K_BR, 5'b00010, 0, 0, 0);
    run_instr(16'hC07F, K_BR, 5'b11101, 0, 0, 0);

    // JAL r14, r3 against the pc model
    pc_m = 16'h8000;
    regs_m[3] = 16'hFFFF;
    regs_m[14] = 16'h0000;
    run_instr(16'h4E83, K_JAL, 5'b0, 0, 0, 0);
    check_val("jal_pc", {16'h0, pc_m}, 32'h0000FFFF);
    check_val("jal_link", {16'h0, regs_m[14]}, 32'h00008001);

    // LOAD and STOR
    run_instr(16'h4302, K_LD, 5'b0, 0, 0, 0);
    run_instr(16'h4142, K_ST, 5'b0, 0, 0, 0);

    // Jcond UC stalled three cycles in EXEC
    run_instr(16'h4EC5, K_JC, 5'b0, 0, 3, 0);

    // Reset dropped in the middle of a STOR MEM cycle
    instr = 16'h4142;
    run_phase(P_FETCH, K_ST, 5'b0, 0);
    ir_m = 16'h4142;
    run_phase(P_EXEC, K_ST, 5'b0, 0);
    exp_q.push_back(expect_vec(P_MEM, K_ST, ir_m, 5'b0, 1'b0));
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_val("rst_mid_mem", {8'h0, dut_vec}, 32'h0);
    @(posedge clk);
    #1;
    ir_m = 16'h0000;
    step(24'h0);
    rst = 1'b1;
    step(24'h0);  // S_RST
    run_instr(16'h510A, K_ALU, 5'b0, 0, 0, 0);

    // Randomised instruction stream with random flags and stalls
    for (int n = 0; n < 300; n++) begin
      gen_instr(w, k);
      run_instr(w, k, 5'($urandom_range(0, 31)), rnd_stall(), rnd_stall(), rnd_stall());
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain got=%0d expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
